// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access pipeline stage.
//   state_e           : access FSM states (IDLE, REQ, DONE)
//   F3_*              : FUNCT3 access size/sign encodings
//   BE_*              : byte-enable patterns
//   access_illegal()  : misalignment / illegal-FUNCT3 predicate. It is used
//                       only when MEM_ALIGN_CHECK_EN is defined.
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Returns 1 when the access is misaligned for its size, or when FUNCT3
  // has no meaning for the requested direction.
  // Unsigned loads have no store counterpart.
  function automatic logic access_illegal(input logic [2:0] funct3,
                                          input logic       is_store,
                                          input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    return 1'b0;
      F3_H:    return addr_lo[0];
      F3_W:    return addr_lo != 2'b00;
      F3_BU:   return is_store;
      F3_HU:   return is_store | addr_lo[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if
// This interface bundles the signals between the pipeline, the stage and the
// data memory.
//   Pipeline -> stage : MEM_READ, MEM_WRITE, ALU_OUTPUT, DATA2, FUNCT3
//   Memory   -> stage : MEM_RDATA, MEM_ACK
//   Stage -> pipeline : BUSYWAIT, LOAD_DATA, ACCESS_FAULT
//   Stage -> memory   : MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BYTE_EN
// The slave modport belongs to the stage. The master modport belongs to the
// pipeline and memory environment.
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] ALU_OUTPUT;
  logic [31:0] DATA2;
  logic [2:0]  FUNCT3;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;
  logic        BUSYWAIT;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] LOAD_DATA;
  logic        ACCESS_FAULT;

  modport master (
    output MEM_READ, MEM_WRITE, ALU_OUTPUT, DATA2, FUNCT3, MEM_RDATA, MEM_ACK,
    input  BUSYWAIT, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BYTE_EN,
           LOAD_DATA, ACCESS_FAULT
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, ALU_OUTPUT, DATA2, FUNCT3, MEM_RDATA, MEM_ACK,
    output BUSYWAIT, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BYTE_EN,
           LOAD_DATA, ACCESS_FAULT
  );
endinterface

// File: rtl/mem_access_stage_load_formatter.sv
// ---------------------------------------------------------------------------
// load_formatter (combinational)
// This module picks the addressed byte or halfword out of a memory word. It
// then sign- or zero-extends the value to 32 bits.
//   rdata_i   : raw word read from memory
//   funct3_i  : access size/sign. Encodings it does not recognise are
//               passed through as a whole word.
//   addr_lo_i : byte offset within the word. A halfword access looks only
//               at bit 1.
//   data_o    : formatted load result
// ---------------------------------------------------------------------------
module load_formatter
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// This is the load/store stage between the EX/MEM register and a
// handshaked data memory. A three-state FSM (IDLE -> REQ -> DONE) latches
// the request, holds the memory bus stable until MEM_ACK arrives, and
// registers the formatted load result.
//   CLK, RESET : single clock and synchronous, active-high reset
//   bus        : mem_access_stage_if.slave. It carries the pipeline
//                request, the memory handshake, BUSYWAIT, LOAD_DATA and
//                ACCESS_FAULT.
//   ACK_TIMEOUT: number of REQ cycles to wait for MEM_ACK before the
//                access is aborted with ACCESS_FAULT
// Configuration macro: MEM_ALIGN_CHECK_EN. When it is defined, a misaligned
// access or an illegal FUNCT3 goes straight from IDLE to DONE and raises
// ACCESS_FAULT. When it is undefined, the low address bits that do not
// apply are ignored.
// ---------------------------------------------------------------------------
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  mem_access_stage_if.slave  bus
);

  localparam int unsigned CNT_NEED = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned CNT_W    = (CNT_NEED > 8) ? CNT_NEED : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [31:0]      load_data_q, load_data_d;

  logic        busy;
  logic        in_req;
  logic        is_store;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] fmt_data;

  load_formatter u_fmt (
    .rdata_i   (bus.MEM_RDATA),
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .data_o    (fmt_data)
  );

  // Store lane steering. A store places its data in every byte lane and
  // lets the byte enables pick the lanes that are written. Any FUNCT3 that
  // is not byte or halfword is stored as a full word.
  always_comb begin
    case (bus.FUNCT3)
      F3_B: begin
        st_be    = BE_BYTE << bus.ALU_OUTPUT[1:0];
        st_wdata = {4{bus.DATA2[7:0]}};
      end
      F3_H: begin
        st_be    = bus.ALU_OUTPUT[1] ? BE_HALF_HI : BE_HALF_LO;
        st_wdata = {2{bus.DATA2[15:0]}};
      end
      default: begin
        st_be    = BE_WORD;
        st_wdata = bus.DATA2;
      end
    endcase
  end

  // A store takes priority when MEM_READ and MEM_WRITE are both high.
  assign is_store = bus.MEM_WRITE;

  always_comb begin
    // NOTE: every _d defaults to its _q first so no branch can infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    load_data_d = load_data_q;
    busy        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.MEM_READ || bus.MEM_WRITE) begin
          busy     = 1'b1;
          addr_d   = bus.ALU_OUTPUT;
          wdata_d  = st_wdata;
          be_d     = is_store ? st_be : BE_NONE;
          we_d     = is_store;
          funct3_d = bus.FUNCT3;
          cnt_d    = '0;
          fault_d  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          if (access_illegal(bus.FUNCT3, is_store, bus.ALU_OUTPUT[1:0])) begin
            state_d     = ST_DONE;
            fault_d     = 1'b1;
            load_data_d = '0;
          end else begin
            state_d = ST_REQ;
          end
`else
          state_d = ST_REQ;
`endif
        end
      end

      ST_REQ: begin
        busy = 1'b1;
        // If MEM_ACK arrives in the last allowed cycle, the access completes
        // normally and does not time out.
        if (bus.MEM_ACK) begin
          if (!we_q) load_data_d = fmt_data;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_DONE;
          fault_d     = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        fault_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase

    // While RESET is high, nothing is stalled. The registers still latch
    // new values here, but the reset branch below overrides them.
    if (RESET) busy = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= BE_NONE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
    end
  end

  assign in_req           = (state_q == ST_REQ);
  assign bus.BUSYWAIT     = busy;
  assign bus.MEM_REQ      = in_req;
  assign bus.MEM_WE       = in_req & we_q;
  assign bus.MEM_BYTE_EN  = in_req ? be_q : BE_NONE;
  assign bus.MEM_ADDR     = {addr_q[31:2], 2'b00};
  assign bus.MEM_WDATA    = wdata_q;
  assign bus.LOAD_DATA    = load_data_q;
  assign bus.ACCESS_FAULT = (state_q == ST_DONE) & fault_q;

endmodule
